// File: rtl/db_pkg.sv
// Shared definitions for the key-value store datapath and its memory responder.
// Widths, status codes and the responder state encoding live here.
package db_pkg;

    localparam int KEY_SIZE   = 96;
    localparam int VAL_SIZE   = 32;
    localparam int RAM_ADDR   = 22;
    localparam int RAM_DWIDTH = 32;

    typedef enum logic [2:0] {
        STAT_NONE  = 3'd0,
        SUSPECTION = 3'd1,
        ARREST     = 3'd2,
        FILTERED   = 3'd3,
        EXPIRED    = 3'd4
    } status_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } resp_state_t;

endpackage

// File: rtl/db_ram_sp.sv
// Single-port synchronous RAM, write-first on a shared address, no reset on contents.
// The memory is cleared by the responder's sweep rather than by a reset network.
module db_ram_sp
    import db_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_din,
    output logic [DWIDTH-1:0] o_dout
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_dout;

    // A write forwards its own data so a same-cycle read sees the new value.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
            r_dout        <= i_din;
        end else begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/db_mem_resp.sv
// On-chip stand-in for the DRAM PHY: zero-fills its RAM after reset, then serves
// reads with a fixed latency and writes immediately, flagging out-of-range and dropped requests.
module db_mem_resp
    import db_pkg::*;
#(
    parameter int RAM_ADDR   = db_pkg::RAM_ADDR,
    parameter int RAM_DWIDTH = db_pkg::RAM_DWIDTH,
    parameter int RAM_SIZE   = 1024,
    parameter int RD_LAT     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [RAM_DWIDTH-1:0] i_wr_din,
    input  logic [RAM_ADDR-1:0]   i_addr,
    input  logic                  i_rd_en,
    output logic [RAM_DWIDTH-1:0] o_rd_dout,
    output logic                  o_rd_valid,
    output logic                  o_ready,
    output logic                  o_oob_err,
    output logic                  o_req_drop
);

    localparam int IDXW = $clog2(RAM_SIZE);

    resp_state_t           r_state;
    resp_state_t           w_state_nxt;
    logic [IDXW-1:0]       r_clr_ptr;

    logic                  w_req;
    logic                  w_ready;
    logic                  w_oob;
    logic                  w_accept;
    logic [IDXW-1:0]       w_idx;

    logic                  w_ram_we;
    logic [IDXW-1:0]       w_ram_addr;
    logic [RAM_DWIDTH-1:0] w_ram_din;
    logic [RAM_DWIDTH-1:0] w_ram_dout;

    logic                  r_rd_v0;
    logic                  r_rd_oob0;
    logic                  r_oob_err;
    logic                  r_req_drop;
    logic [RAM_DWIDTH-1:0] w_stage0_data;
    logic                  w_out_valid;
    logic [RAM_DWIDTH-1:0] w_out_data;
    logic [RAM_DWIDTH-1:0] r_hold;

    assign w_req   = i_wr_en | i_rd_en;
    assign w_ready = (r_state == RUN);
    assign w_idx   = i_addr[IDXW-1:0];
    // Range check uses the full address so aliased high addresses are caught.
    assign w_oob   = ({1'b0, i_addr} >= (RAM_ADDR+1)'(RAM_SIZE));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= INIT;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_clr_ptr <= r_clr_ptr + IDXW'(1);
            end
        end
    end

    // The sweep owns the RAM port during INIT; requests get it only in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_addr  = w_idx;
        w_ram_din   = i_wr_din;
        w_accept    = 1'b0;
        case (r_state)
            INIT: begin
                w_ram_we   = 1'b1;
                w_ram_addr = r_clr_ptr;
                w_ram_din  = '0;
                if (r_clr_ptr == IDXW'(RAM_SIZE - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_accept = w_req;
                w_ram_we = i_wr_en & ~w_oob;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    db_ram_sp #(
        .DEPTH  (RAM_SIZE),
        .DWIDTH (RAM_DWIDTH),
        .AWIDTH (IDXW)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_din  (w_ram_din),
        .o_dout (w_ram_dout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_v0    <= 1'b0;
            r_rd_oob0  <= 1'b0;
            r_oob_err  <= 1'b0;
            r_req_drop <= 1'b0;
        end else begin
            r_rd_v0    <= w_accept & i_rd_en;
            r_rd_oob0  <= w_accept & i_rd_en & w_oob;
            r_oob_err  <= w_accept & w_oob;
            r_req_drop <= w_req & ~w_ready;
        end
    end

    // Out-of-range reads return zero regardless of what the aliased word holds.
    assign w_stage0_data = r_rd_oob0 ? '0 : w_ram_dout;

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign w_out_valid = r_rd_v0;
            assign w_out_data  = w_stage0_data;
        end else begin : g_latn
            logic [RD_LAT-2:0]     r_pv;
            logic [RAM_DWIDTH-1:0] r_pd [RD_LAT-1];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_pv <= '0;
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        r_pd[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= r_rd_v0;
                    r_pd[0] <= w_stage0_data;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pd[i] <= r_pd[i-1];
                    end
                end
            end

            assign w_out_valid = r_pv[RD_LAT-2];
            assign w_out_data  = r_pd[RD_LAT-2];
        end
    endgenerate

    // Keeps rd_dout steady between pulses so it never shows pipeline garbage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_out_valid) begin
            r_hold <= w_out_data;
        end
    end

    assign o_rd_valid = w_out_valid;
    assign o_rd_dout  = w_out_valid ? w_out_data : r_hold;
    assign o_ready    = w_ready;
    assign o_oob_err  = r_oob_err;
    assign o_req_drop = r_req_drop;

endmodule

// File: doc/db_mem_resp.md
Name: db_mem_resp

Overview:
- Memory-side responder for the db_cont DRAM request interface: the receiving end of its dram_wr_en/dram_wr_din/dram_addr/dram_rd_en, returning dram_rd_dout/dram_rd_valid.
- Backs the key-value store with on-chip RAM until the real DRAM PHY lands; the port list matches the PHY's so the swap is a drop-in.
- Zero-fills memory after every reset and gives reads a fixed, parameterised latency.

Parameters:
- RAM_ADDR, 22, request address width (word address).
- RAM_DWIDTH, 32, data width.
- RAM_SIZE, 1024, number of implemented words (power of two); index = addr[log2(RAM_SIZE)-1:0].
- RD_LAT, 2, cycles from accepted rd_en to rd_valid (legal range 1..8).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request strobe.
- wr_din  in  RAM_DWIDTH  write data.
- addr  in  RAM_ADDR  word address for read or write.
- rd_en  in  1  read request strobe.
- rd_dout  out  RAM_DWIDTH  read data, valid only while rd_valid=1.
- rd_valid  out  1  one-cycle pulse per accepted read.
- ready  out  1  requests are accepted only while ready=1.
- oob_err  out  1  one-cycle pulse: accepted request with addr >= RAM_SIZE.
- req_drop  out  1  one-cycle pulse: wr_en or rd_en asserted while ready=0.

Behaviour:
- Reset values: ready=0, rd_valid=0, rd_dout=0, oob_err=0, req_drop=0, FSM=INIT, clear pointer=0, latency pipeline flushed.
- FSM has two states, INIT and RUN.
- INIT: each cycle, write 0 to RAM[clr_ptr], then clr_ptr++. After writing index RAM_SIZE-1, go to RUN. ready rises the next cycle, i.e. RAM_SIZE cycles after rst deasserts.
- RUN: ready=1 permanently. There is no other path out of RUN except reset.
- Acceptance: a request is accepted when (wr_en|rd_en) & ready in cycle T.
- Write: RAM[idx] <= wr_din at the T edge.
- Read: rd_valid=1 and rd_dout=data in cycle T+RD_LAT. A read accepted every cycle gives back-to-back rd_valid with no bubbles, returned in order.
- Simultaneous wr_en & rd_en (same addr by construction): write-first. The write is performed and the read returns wr_din.
- Read of an address written at T-1 or earlier returns the new data; there is no stale-read window.
- Out of range (addr >= RAM_SIZE, compared on the full RAM_ADDR width):
  - a write is discarded;
  - a read still produces rd_valid at T+RD_LAT, with rd_dout=0;
  - oob_err pulses at T+1.
- Requests while ready=0: ignored, with no RAM access and no rd_valid; req_drop pulses at T+1.
- Reset mid-operation: in-flight reads are cancelled, with no rd_valid after rst rises. The FSM returns to INIT and the clear sweep restarts at index 0. RAM contents are undefined until the sweep completes.
- Latency pipeline: a RD_LAT-deep shift register of {valid, data, oob}. The RAM itself is a 1-cycle synchronous read; the remaining RD_LAT-1 stages are registers.
- rd_dout holds its last value when rd_valid=0. Consumers must not sample it then.

Decomposition:
- Shared package db_pkg holds:
  - default widths KEY_SIZE=96, VAL_SIZE=32, RAM_ADDR=22, RAM_DWIDTH=32;
  - status codes SUSPECTION=1, ARREST=2, FILTERED=3, EXPIRED=4;
  - FSM state encoding INIT/RUN.
- One sub-module, db_ram_sp: single-port, synchronous, write-first RAM (RAM_SIZE x RAM_DWIDTH) with no reset on its contents. The responder owns the FSM, the clear sweep, range check and latency pipeline.

Test Plan:
- Reset then idle, RAM_SIZE=1024: ready=0 for exactly 1024 cycles after rst falls, then 1. Read of addr 5 returns 0x00000000 at T+2.
- Write 0xDEADBEEF to addr 7 at T, read addr 7 at T+1: rd_valid=1 and rd_dout=0xDEADBEEF at T+3.
- Streaming reads, addr 0..15 back-to-back after writing value=addr+0x100: 16 consecutive rd_valid pulses, data 0x100..0x10F in order, no gaps.
- wr_en & rd_en together, addr 3, wr_din 0xA5A5A5A5: write lands and rd_dout=0xA5A5A5A5 at T+2. Also addr 0x000400: oob_err at T+1, write dropped, read returns 0 with rd_valid.
- rd_en during INIT: no rd_valid, req_drop pulses at T+1.
- Reads issued at T and T+1, rst raised at T+1: no rd_valid ever appears. The sweep restarts, ready returns after 1024 cycles, and the previously written addr 7 reads 0.
